serv_bus_arbiter: RTL and testbench

Sequential arbiter that shares one Wishbone master port between the SERV instruction bus and data bus. It holds a registered grant for the whole transaction and alternates priority between the two buses. It inserts a mandatory idle cycle between transactions and ends hung transactions with a watchdog timeout. It sits between the core (ibus/dbus) and the system interconnect.

---
 rtl/serv_bus_arbiter_pkg.sv | 12 +
 rtl/serv_bus_watchdog.sv | 38 +++
 rtl/serv_bus_arbiter.sv | 113 +++++++++++
 tb/tb_serv_bus_arbiter.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serv_bus_arbiter_pkg.sv
// Shared definitions for the SERV ibus/dbus Wishbone arbiter.
package serv_bus_arbiter_pkg;

    localparam int unsigned DEFAULT_TIMEOUT_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } arb_state_t;

endpackage

// File: rtl/serv_bus_watchdog.sv
// Watchdog for a granted transaction: counts granted cycles and flags a hung bus.
module serv_bus_watchdog
    import serv_bus_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_W = DEFAULT_TIMEOUT_W
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_start,
    input  logic i_grant,
    input  logic i_hit,
    output logic o_tmo_c,
    output logic o_timeout
);

    localparam logic [TIMEOUT_W-1:0] CNT_MAX = {TIMEOUT_W{1'b1}};

    logic [TIMEOUT_W-1:0] count;

    assign o_tmo_c = i_grant & (count == CNT_MAX);

    // count holds the index of the current granted cycle (first granted cycle = 1)
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            count     <= '0;
            o_timeout <= 1'b0;
        end else begin
            o_timeout <= o_tmo_c & ~i_hit;
            if (i_start)
                count <= TIMEOUT_W'(1);
            else if (!i_grant || i_hit)
                count <= '0;
            else
                count <= TIMEOUT_W'(count + 1'b1);
        end
    end

endmodule

// File: rtl/serv_bus_arbiter.sv
// Shares one Wishbone master port between SERV ibus and dbus with round-robin
// priority, a mandatory idle cycle between transactions and a hang watchdog.
module serv_bus_arbiter
    import serv_bus_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_W    = DEFAULT_TIMEOUT_W,
    parameter bit          WITH_TIMEOUT = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_ibus_adr,
    input  logic        i_ibus_cyc,
    output logic [31:0] o_ibus_rdt,
    output logic        o_ibus_ack,
    input  logic [31:0] i_dbus_adr,
    input  logic [31:0] i_dbus_dat,
    input  logic [3:0]  i_dbus_sel,
    input  logic        i_dbus_we,
    input  logic        i_dbus_cyc,
    output logic [31:0] o_dbus_rdt,
    output logic        o_dbus_ack,
    output logic [31:0] o_wb_adr,
    output logic [31:0] o_wb_dat,
    output logic [3:0]  o_wb_sel,
    output logic        o_wb_we,
    output logic        o_wb_cyc,
    input  logic [31:0] i_wb_rdt,
    input  logic        i_wb_ack,
    input  logic        i_wb_err,
    output logic        o_timeout,
    output logic        o_bus_err
);

    arb_state_t  state;
    logic        last_d;
    logic        tmo;
    logic        term;
    logic        zero_rdt;
    logic        start;
    logic [31:0] rdt;

    assign o_wb_cyc = (state != IDLE);
    assign term     = o_wb_cyc & (i_wb_ack | i_wb_err | tmo);
    assign zero_rdt = i_wb_err | (tmo & ~i_wb_ack);
    assign start    = (state == IDLE) & (i_ibus_cyc | i_dbus_cyc);
    assign rdt      = zero_rdt ? 32'h0 : i_wb_rdt;

    assign o_ibus_ack = (state == GNT_I) & term;
    assign o_dbus_ack = (state == GNT_D) & term;
    assign o_ibus_rdt = rdt;
    assign o_dbus_rdt = rdt;

    assign o_wb_adr = (state == GNT_I) ? i_ibus_adr : i_dbus_adr;
    assign o_wb_sel = (state == GNT_I) ? 4'hf : i_dbus_sel;
    assign o_wb_dat = i_dbus_dat;
    assign o_wb_we  = (state == GNT_D) & i_dbus_we;

    // Grant FSM; last_d=1 means dbus was served most recently
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state     <= IDLE;
            last_d    <= 1'b1;
            o_bus_err <= 1'b0;
        end else begin
            o_bus_err <= term & i_wb_err;
            case (state)
                IDLE: begin
                    if (i_ibus_cyc && (!i_dbus_cyc || last_d))
                        state <= GNT_I;
                    else if (i_dbus_cyc)
                        state <= GNT_D;
                end
                GNT_I: begin
                    if (term) begin
                        state  <= IDLE;
                        last_d <= 1'b0;
                    end else if (!i_ibus_cyc) begin
                        state <= IDLE;
                    end
                end
                GNT_D: begin
                    if (term) begin
                        state  <= IDLE;
                        last_d <= 1'b1;
                    end else if (!i_dbus_cyc) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    generate
        if (WITH_TIMEOUT) begin : g_wdog
            serv_bus_watchdog #(
                .TIMEOUT_W (TIMEOUT_W)
            ) u_wdog (
                .i_clk     (i_clk),
                .i_rst     (i_rst),
                .i_start   (start),
                .i_grant   (o_wb_cyc),
                .i_hit     (i_wb_ack | i_wb_err),
                .o_tmo_c   (tmo),
                .o_timeout (o_timeout)
            );
        end else begin : g_no_wdog
            assign tmo       = 1'b0;
            assign o_timeout = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_serv_bus_arbiter.sv
// Scoreboard bench for serv_bus_arbiter: inputs change 1 time unit after the rising edge.
module tb_serv_bus_arbiter;

    logic        clk;
    logic        i_rst;
    logic [31:0] i_ibus_adr;
    logic        i_ibus_cyc;
    logic [31:0] o_ibus_rdt;
    logic        o_ibus_ack;
    logic [31:0] i_dbus_adr;
    logic [31:0] i_dbus_dat;
    logic [3:0]  i_dbus_sel;
    logic        i_dbus_we;
    logic        i_dbus_cyc;
    logic [31:0] o_dbus_rdt;
    logic        o_dbus_ack;
    logic [31:0] o_wb_adr;
    logic [31:0] o_wb_dat;
    logic [3:0]  o_wb_sel;
    logic        o_wb_we;
    logic        o_wb_cyc;
    logic [31:0] i_wb_rdt;
    logic        i_wb_ack;
    logic        i_wb_err;
    logic        o_timeout;
    logic        o_bus_err;

    typedef struct packed {
        logic        dbus;
        logic [31:0] rdt;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;

    serv_bus_arbiter #(
        .TIMEOUT_W    (3),
        .WITH_TIMEOUT (1'b1)
    ) dut (
        .i_clk      (clk),
        .i_rst      (i_rst),
        .i_ibus_adr (i_ibus_adr),
        .i_ibus_cyc (i_ibus_cyc),
        .o_ibus_rdt (o_ibus_rdt),
        .o_ibus_ack (o_ibus_ack),
        .i_dbus_adr (i_dbus_adr),
        .i_dbus_dat (i_dbus_dat),
        .i_dbus_sel (i_dbus_sel),
        .i_dbus_we  (i_dbus_we),
        .i_dbus_cyc (i_dbus_cyc),
        .o_dbus_rdt (o_dbus_rdt),
        .o_dbus_ack (o_dbus_ack),
        .o_wb_adr   (o_wb_adr),
        .o_wb_dat   (o_wb_dat),
        .o_wb_sel   (o_wb_sel),
        .o_wb_we    (o_wb_we),
        .o_wb_cyc   (o_wb_cyc),
        .i_wb_rdt   (i_wb_rdt),
        .i_wb_ack   (i_wb_ack),
        .i_wb_err   (i_wb_err),
        .o_timeout  (o_timeout),
        .o_bus_err  (o_bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        i_ibus_adr = '0; i_ibus_cyc = 1'b0;
        i_dbus_adr = '0; i_dbus_dat = '0; i_dbus_sel = '0; i_dbus_we = 1'b0; i_dbus_cyc = 1'b0;
        i_wb_rdt = '0; i_wb_ack = 1'b0; i_wb_err = 1'b0;
        repeat (2) tick();
        i_ibus_cyc = 1'b1; i_wb_ack = 1'b1;
        tick();
        checks++; if (o_wb_cyc !== 1'b0) begin errors++; $display("FAIL reset_cyc got %b want 0", o_wb_cyc); end
        checks++; if (o_ibus_ack !== 1'b0) begin errors++; $display("FAIL reset_ack got %b want 0", o_ibus_ack); end
        checks++; if (o_timeout !== 1'b0 || o_bus_err !== 1'b0) begin errors++; $display("FAIL reset_pulses got %b%b want 00", o_timeout, o_bus_err); end
        i_ibus_cyc = 1'b0; i_wb_ack = 1'b0;
        i_rst = 1'b0;
        tick();
        checks++; if (o_wb_cyc !== 1'b0) begin errors++; $display("FAIL reset_idle got %b want 0", o_wb_cyc); end
    endtask

    task automatic test_fetch();
        int ncyc = 0;
        i_ibus_adr = 32'h100; i_ibus_cyc = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            if (o_wb_cyc) ncyc++;
            checks++; if (o_wb_adr !== 32'h100 || o_wb_we !== 1'b0 || o_wb_sel !== 4'hf) begin
                errors++; $display("FAIL fetch_bus k=%0d got adr=%h we=%b sel=%h want 100/0/f", k, o_wb_adr, o_wb_we, o_wb_sel); end
            if (k == 3) begin
                i_wb_ack = 1'b1; i_wb_rdt = 32'h13;
                sb.push_back('{dbus: 1'b0, rdt: 32'h13});
            end
            #1;
            if (k == 3) begin
                e = sb.pop_front();
                checks++; if (o_ibus_ack !== 1'b1 || o_ibus_rdt !== e.rdt) begin
                    errors++; $display("FAIL fetch_ack got ack=%b rdt=%h want 1/%h", o_ibus_ack, o_ibus_rdt, e.rdt); end
            end else begin
                checks++; if (o_ibus_ack !== 1'b0) begin errors++; $display("FAIL fetch_early_ack k=%0d got %b want 0", k, o_ibus_ack); end
            end
        end
        tick();
        i_wb_ack = 1'b0; i_wb_rdt = '0;
        checks++; if (o_wb_cyc !== 1'b0 || o_ibus_ack !== 1'b0) begin
            errors++; $display("FAIL fetch_idle got cyc=%b ack=%b want 0/0", o_wb_cyc, o_ibus_ack); end
        i_ibus_cyc = 1'b0;
        checks++; if (ncyc !== 3) begin errors++; $display("FAIL fetch_len got %0d want 3", ncyc); end
    endtask

    task automatic test_store();
        i_dbus_adr = 32'h2000; i_dbus_dat = 32'hDEADBEEF; i_dbus_sel = 4'b0011; i_dbus_we = 1'b1; i_dbus_cyc = 1'b1;
        #1;
        checks++; if (o_wb_we !== 1'b0) begin errors++; $display("FAIL store_we_idle got %b want 0", o_wb_we); end
        tick();
        checks++; if (o_wb_cyc !== 1'b1 || o_wb_adr !== 32'h2000 || o_wb_dat !== 32'hDEADBEEF || o_wb_sel !== 4'b0011 || o_wb_we !== 1'b1) begin
            errors++; $display("FAIL store_bus got cyc=%b adr=%h dat=%h sel=%b we=%b want 1/2000/deadbeef/0011/1",
                               o_wb_cyc, o_wb_adr, o_wb_dat, o_wb_sel, o_wb_we); end
        i_wb_ack = 1'b1; i_wb_rdt = 32'h55;
        sb.push_back('{dbus: 1'b1, rdt: 32'h55});
        #1;
        e = sb.pop_front();
        checks++; if (o_dbus_ack !== 1'b1 || o_ibus_ack !== 1'b0 || o_dbus_rdt !== e.rdt) begin
            errors++; $display("FAIL store_ack got d=%b i=%b rdt=%h want 1/0/%h", o_dbus_ack, o_ibus_ack, o_dbus_rdt, e.rdt); end
        tick();
        i_wb_ack = 1'b0; i_dbus_cyc = 1'b0;
        checks++; if (o_wb_we !== 1'b0 || o_wb_cyc !== 1'b0) begin
            errors++; $display("FAIL store_after got we=%b cyc=%b want 0/0", o_wb_we, o_wb_cyc); end
        i_dbus_we = 1'b0;
    endtask

    task automatic test_contention();
        logic [31:0] got;
        i_rst = 1'b1;
        #1;
        i_rst = 1'b0;
        i_ibus_adr = 32'hA0; i_dbus_adr = 32'hB0;
        i_ibus_cyc = 1'b1; i_dbus_cyc = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            i_wb_ack = o_wb_cyc;
            i_wb_rdt = 32'h1000 + 32'(k);
            if (k % 2 == 1) sb.push_back('{dbus: ((k / 2) % 2 == 1), rdt: 32'h1000 + 32'(k)});
            #1;
            checks++; if (o_wb_cyc !== (k % 2 == 1)) begin errors++; $display("FAIL cont_cyc k=%0d got %b want %b", k, o_wb_cyc, (k % 2 == 1)); end
            if (k % 2 == 1) begin
                e = sb.pop_front();
                got = e.dbus ? o_dbus_rdt : o_ibus_rdt;
                checks++; if (o_wb_adr !== (e.dbus ? 32'hB0 : 32'hA0) || o_dbus_ack !== e.dbus || o_ibus_ack !== ~e.dbus || got !== e.rdt) begin
                    errors++; $display("FAIL cont_grant k=%0d got adr=%h i=%b d=%b rdt=%h want dbus=%b rdt=%h",
                                       k, o_wb_adr, o_ibus_ack, o_dbus_ack, got, e.dbus, e.rdt); end
            end
        end
        i_wb_ack = 1'b0; i_ibus_cyc = 1'b0; i_dbus_cyc = 1'b0;
        tick();
    endtask

    task automatic test_timeout();
        i_dbus_cyc = 1'b1; i_wb_rdt = 32'hFFFFFFFF;
        sb.push_back('{dbus: 1'b1, rdt: 32'h0});
        for (int k = 1; k <= 7; k++) begin
            tick();
            checks++; if (o_timeout !== 1'b0 || o_wb_cyc !== 1'b1) begin
                errors++; $display("FAIL tmo_wait k=%0d got tmo=%b cyc=%b want 0/1", k, o_timeout, o_wb_cyc); end
            if (k == 7) begin
                e = sb.pop_front();
                checks++; if (o_dbus_ack !== 1'b1 || o_dbus_rdt !== e.rdt) begin
                    errors++; $display("FAIL tmo_ack got ack=%b rdt=%h want 1/%h", o_dbus_ack, o_dbus_rdt, e.rdt); end
            end else begin
                checks++; if (o_dbus_ack !== 1'b0) begin errors++; $display("FAIL tmo_early k=%0d got %b want 0", k, o_dbus_ack); end
            end
        end
        tick();
        i_dbus_cyc = 1'b0;
        checks++; if (o_timeout !== 1'b1 || o_wb_cyc !== 1'b0) begin
            errors++; $display("FAIL tmo_pulse got tmo=%b cyc=%b want 1/0", o_timeout, o_wb_cyc); end
        tick();
        checks++; if (o_timeout !== 1'b0) begin errors++; $display("FAIL tmo_pulse_len got %b want 0", o_timeout); end
        i_dbus_cyc = 1'b1; i_wb_rdt = 32'h77;
        sb.push_back('{dbus: 1'b1, rdt: 32'h77});
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k == 7) i_wb_ack = 1'b1;
            #1;
            if (k == 7) begin
                e = sb.pop_front();
                checks++; if (o_dbus_ack !== 1'b1 || o_dbus_rdt !== e.rdt) begin
                    errors++; $display("FAIL tmo_ack_race got ack=%b rdt=%h want 1/%h", o_dbus_ack, o_dbus_rdt, e.rdt); end
            end
        end
        tick();
        i_wb_ack = 1'b0; i_dbus_cyc = 1'b0;
        checks++; if (o_timeout !== 1'b0) begin errors++; $display("FAIL tmo_race_pulse got %b want 0", o_timeout); end
        tick();
    endtask

    task automatic test_error_abort();
        i_ibus_adr = 32'h300; i_ibus_cyc = 1'b1;
        tick();
        i_wb_ack = 1'b1; i_wb_err = 1'b1; i_wb_rdt = 32'h1234;
        sb.push_back('{dbus: 1'b0, rdt: 32'h0});
        #1;
        e = sb.pop_front();
        checks++; if (o_ibus_ack !== 1'b1 || o_ibus_rdt !== e.rdt || o_bus_err !== 1'b0) begin
            errors++; $display("FAIL err_ack got ack=%b rdt=%h berr=%b want 1/%h/0", o_ibus_ack, o_ibus_rdt, o_bus_err, e.rdt); end
        tick();
        i_wb_ack = 1'b0; i_wb_err = 1'b0; i_ibus_cyc = 1'b0;
        checks++; if (o_bus_err !== 1'b1 || o_wb_cyc !== 1'b0) begin
            errors++; $display("FAIL err_pulse got berr=%b cyc=%b want 1/0", o_bus_err, o_wb_cyc); end
        tick();
        checks++; if (o_bus_err !== 1'b0) begin errors++; $display("FAIL err_pulse_len got %b want 0", o_bus_err); end
        // last grant is now ibus; abort a dbus grant and confirm priority is untouched
        i_dbus_adr = 32'hB0; i_dbus_cyc = 1'b1;
        tick();
        tick();
        i_dbus_cyc = 1'b0;
        #1;
        checks++; if (o_wb_cyc !== 1'b1 || o_dbus_ack !== 1'b0) begin
            errors++; $display("FAIL abort_drop got cyc=%b ack=%b want 1/0", o_wb_cyc, o_dbus_ack); end
        tick();
        checks++; if (o_wb_cyc !== 1'b0 || o_dbus_ack !== 1'b0) begin
            errors++; $display("FAIL abort_idle got cyc=%b ack=%b want 0/0", o_wb_cyc, o_dbus_ack); end
        i_ibus_adr = 32'hA0; i_ibus_cyc = 1'b1; i_dbus_cyc = 1'b1;
        tick();
        i_wb_ack = 1'b1; i_wb_rdt = 32'h99;
        sb.push_back('{dbus: 1'b1, rdt: 32'h99});
        #1;
        e = sb.pop_front();
        checks++; if (o_wb_adr !== 32'hB0 || o_dbus_ack !== e.dbus || o_dbus_rdt !== e.rdt) begin
            errors++; $display("FAIL abort_rr got adr=%h dack=%b rdt=%h want b0/1/%h", o_wb_adr, o_dbus_ack, o_dbus_rdt, e.rdt); end
        tick();
        i_wb_ack = 1'b0; i_ibus_cyc = 1'b0; i_dbus_cyc = 1'b0;
        tick();
    endtask

    task automatic test_async_reset();
        i_ibus_adr = 32'h400; i_ibus_cyc = 1'b1;
        tick();
        checks++; if (o_wb_cyc !== 1'b1) begin errors++; $display("FAIL arst_pre got %b want 1", o_wb_cyc); end
        #2;
        i_wb_ack = 1'b1; i_rst = 1'b1;
        #1;
        checks++; if (o_wb_cyc !== 1'b0 || o_ibus_ack !== 1'b0) begin
            errors++; $display("FAIL arst_drop got cyc=%b ack=%b want 0/0", o_wb_cyc, o_ibus_ack); end
        i_wb_ack = 1'b0;
        #1;
        i_rst = 1'b0;
        #1;
        checks++; if (o_wb_cyc !== 1'b0) begin errors++; $display("FAIL arst_release got %b want 0", o_wb_cyc); end
        tick();
        checks++; if (o_wb_cyc !== 1'b1 || o_wb_adr !== 32'h400) begin
            errors++; $display("FAIL arst_regrant got cyc=%b adr=%h want 1/400", o_wb_cyc, o_wb_adr); end
        i_wb_ack = 1'b1; i_wb_rdt = 32'h4;
        sb.push_back('{dbus: 1'b0, rdt: 32'h4});
        #1;
        e = sb.pop_front();
        checks++; if (o_ibus_ack !== 1'b1 || o_ibus_rdt !== e.rdt) begin
            errors++; $display("FAIL arst_ack got ack=%b rdt=%h want 1/%h", o_ibus_ack, o_ibus_rdt, e.rdt); end
        tick();
        i_wb_ack = 1'b0; i_ibus_cyc = 1'b0;
        tick();
    endtask

    initial begin
        i_rst = 1'b1;
        test_reset();
        test_fetch();
        test_store();
        test_contention();
        test_timeout();
        test_error_abort();
        test_async_reset();
        checks++; if (sb.size() !== 0) begin errors++; $display("FAIL sb_drain got %0d want 0", sb.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL sim_timeout got running want finished");
        $fatal(1);
    end

endmodule
